// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback slice.
// Condition codes, flag bit positions and queue states.
package alu_writeback_pkg;

   localparam logic [3:0] COND_AL = 4'd0;
   localparam logic [3:0] COND_EQ = 4'd1;
   localparam logic [3:0] COND_NE = 4'd2;
   localparam logic [3:0] COND_CS = 4'd3;
   localparam logic [3:0] COND_CC = 4'd4;
   localparam logic [3:0] COND_MI = 4'd5;
   localparam logic [3:0] COND_PL = 4'd6;
   localparam logic [3:0] COND_VS = 4'd7;
   localparam logic [3:0] COND_VC = 4'd8;
   localparam logic [3:0] COND_GE = 4'd9;
   localparam logic [3:0] COND_LT = 4'd10;
   localparam logic [3:0] COND_GT = 4'd11;
   localparam logic [3:0] COND_LE = 4'd12;
   localparam logic [3:0] COND_NV = 4'd13;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      Q_EMPTY = 2'd0,
      Q_ONE   = 2'd1,
      Q_TWO   = 2'd2
   } q_state_e;

endpackage

// File: rtl/alu_writeback_cond_eval.sv
// Condition-code evaluator against the NZCV flag register.
// Codes 13..15 never pass.
module alu_cond_eval
   import alu_writeback_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // decode the condition code into a single pass bit
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_AL: pass = 1'b1;
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: NZCV register, retire counter, 2-entry skid queue.
// Define ALU_WB_COND_EN to enable condition-code evaluation.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_c,
   input  logic              alu_v,
   input  logic [ADDR_W-1:0] dest_addr,
   input  logic              wb_en,
   input  logic              flag_en,
   input  logic [3:0]        cond,
   output logic              rf_valid,
   input  logic              rf_ready,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_data,
   output logic [3:0]        flags_q,
   output logic [15:0]       retired
);

   q_state_e          state_q, state_d;
   logic [ADDR_W-1:0] head_addr_q, head_addr_d;
   logic [DATA_W-1:0] head_data_q, head_data_d;
   logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
   logic [DATA_W-1:0] tail_data_q, tail_data_d;
   logic [15:0]       retired_q;

   logic accept;
   logic pass;
   logic enq;
   logic deq;

`ifdef ALU_WB_COND_EN
   alu_cond_eval u_cond (
      .cond  (cond),
      .flags (flags_q),
      .pass  (pass)
   );
`else
   logic unused_cond;
   assign unused_cond = ^cond;
   assign pass = 1'b1;
`endif

   // ready depends on registered state only
   assign in_ready = (state_q != Q_TWO);
   assign rf_valid = (state_q != Q_EMPTY);
   assign rf_addr  = head_addr_q;
   assign rf_data  = head_data_q;
   assign retired  = retired_q;

   assign accept = in_valid && in_ready;
   assign enq    = accept && pass && wb_en;
   assign deq    = rf_valid && rf_ready;

   // queue next state: new entries go to head when it frees up
   always_comb begin
      state_d     = state_q;
      head_addr_d = head_addr_q;
      head_data_d = head_data_q;
      tail_addr_d = tail_addr_q;
      tail_data_d = tail_data_q;
      case (state_q)
         Q_EMPTY: begin
            if (enq) begin
               state_d     = Q_ONE;
               head_addr_d = dest_addr;
               head_data_d = alu_data;
            end
         end
         Q_ONE: begin
            if (enq && deq) begin
               head_addr_d = dest_addr;
               head_data_d = alu_data;
            end else if (enq) begin
               state_d     = Q_TWO;
               tail_addr_d = dest_addr;
               tail_data_d = alu_data;
            end else if (deq) begin
               state_d = Q_EMPTY;
            end
         end
         Q_TWO: begin
            if (deq) begin
               state_d     = Q_ONE;
               head_addr_d = tail_addr_q;
               head_data_d = tail_data_q;
            end
         end
         default: state_d = Q_EMPTY;
      endcase
   end

   // queue state and entry registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= Q_EMPTY;
         head_addr_q <= '0;
         head_data_q <= '0;
         tail_addr_q <= '0;
         tail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         head_addr_q <= head_addr_d;
         head_data_q <= head_data_d;
         tail_addr_q <= tail_addr_d;
         tail_data_q <= tail_data_d;
      end
   end

   // architectural flags update only on passing flag-setting accepts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else if (accept && pass && flag_en) begin
         flags_q <= {alu_n, alu_z, alu_c, alu_v};
      end
   end

   // every accept retires, including condition-failed ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else if (accept) begin
         retired_q <= retired_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized bench for alu_writeback against a queue-based model.
// Honours ALU_WB_COND_EN the same way as the design.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] alu_data;
   logic        alu_n, alu_z, alu_c, alu_v;
   logic [2:0]  dest_addr;
   logic        wb_en, flag_en;
   logic [3:0]  cond;
   logic        rf_valid, rf_ready;
   logic [2:0]  rf_addr;
   logic [15:0] rf_data;
   logic [3:0]  flags_q;
   logic [15:0] retired;

   int errors = 0;
   int checks = 0;
   int r5_cnt = 0;

   logic [18:0] mq[$];
   logic [3:0]  mflags;
   logic [15:0] mret;

   alu_writeback #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_data(alu_data),
      .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .dest_addr(dest_addr), .wb_en(wb_en), .flag_en(flag_en),
      .cond(cond),
      .rf_valid(rf_valid), .rf_ready(rf_ready),
      .rf_addr(rf_addr), .rf_data(rf_data),
      .flags_q(flags_q), .retired(retired)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (rst_n && rf_valid && rf_ready && rf_addr == 3'd5)
         r5_cnt++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_pass(input logic [3:0] c,
                                     input logic [3:0] f);
`ifdef ALU_WB_COND_EN
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return 1'b1;
         4'd1:  return z;
         4'd2:  return !z;
         4'd3:  return cy;
         4'd4:  return !cy;
         4'd5:  return n;
         4'd6:  return !n;
         4'd7:  return v;
         4'd8:  return !v;
         4'd9:  return n == v;
         4'd10: return n != v;
         4'd11: return !z && n == v;
         4'd12: return z || n != v;
         default: return 1'b0;
      endcase
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      mflags = 4'b0000;
      mret   = 16'd0;
   endtask

   task automatic compare_all();
      chk("rf_valid", rf_valid, mq.size() != 0);
      chk("in_ready", in_ready, mq.size() < 2);
      chk("flags", flags_q, mflags);
      chk("retired", retired, mret);
      if (mq.size() != 0) begin
         chk("rf_addr", rf_addr, mq[0][18:16]);
         chk("rf_data", rf_data, mq[0][15:0]);
      end
   endtask

   // entered at a falling edge; checks, drives, advances one cycle
   task automatic step(input logic v, input logic [15:0] d,
                       input logic [2:0] a, input logic wb,
                       input logic fe, input logic [3:0] fl,
                       input logic [3:0] c, input logic rr);
      bit acc, dq, p;
      compare_all();
      in_valid  = v;
      alu_data  = d;
      dest_addr = a;
      wb_en     = wb;
      flag_en   = fe;
      {alu_n, alu_z, alu_c, alu_v} = fl;
      cond      = c;
      rf_ready  = rr;
      acc = v && (mq.size() < 2);
      dq  = rr && (mq.size() > 0);
      p   = model_pass(c, mflags);
      if (dq) void'(mq.pop_front());
      if (acc) begin
         mret++;
         if (p && fe) mflags = fl;
         if (p && wb) mq.push_back({a, d});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && mq.size() > 0; i++)
         step(0, 16'h0, 3'd0, 0, 0, 4'h0, 4'd0, 1);
      step(0, 16'h0, 3'd0, 0, 0, 4'h0, 4'd0, 1);
      chk("drained", rf_valid, 1'b0);
   endtask

   initial begin
      int r0, k0;
      rst_n = 1'b0;
      in_valid = 0; alu_data = 0; dest_addr = 0;
      wb_en = 0; flag_en = 0; cond = 0; rf_ready = 0;
      {alu_n, alu_z, alu_c, alu_v} = 4'h0;
      model_reset();
      #12;
      chk("rst_valid", rf_valid, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_flags", flags_q, 4'h0);
      chk("rst_ret", retired, 16'h0);
      chk("rst_addr", rf_addr, 3'd0);
      chk("rst_data", rf_data, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // simple writeback
      step(1, 16'h0002, 3'd3, 1, 1, 4'b0010, 4'd0, 0);
      chk("wb_valid", rf_valid, 1'b1);
      chk("wb_addr", rf_addr, 3'd3);
      chk("wb_data", rf_data, 16'h0002);
      chk("wb_flags", flags_q, 4'b0010);
      drain();

      // back-pressure: third write held until two drain
      step(1, 16'h8000, 3'd1, 1, 0, 4'h0, 4'd0, 0);
      step(1, 16'h4000, 3'd2, 1, 0, 4'h0, 4'd0, 0);
      chk("bp_full", in_ready, 1'b0);
      step(1, 16'h1111, 3'd4, 1, 0, 4'h0, 4'd0, 0);
      chk("bp_head0", rf_data, 16'h8000);
      step(1, 16'h1111, 3'd4, 1, 0, 4'h0, 4'd0, 1);
      chk("bp_head1", rf_data, 16'h4000);
      step(1, 16'h1111, 3'd4, 1, 0, 4'h0, 4'd0, 1);
      chk("bp_head2", rf_data, 16'h1111);
      drain();

      // simultaneous enqueue and dequeue in ONE
      step(1, 16'h0055, 3'd6, 1, 0, 4'h0, 4'd0, 0);
      step(1, 16'h00AA, 3'd7, 1, 0, 4'h0, 4'd0, 1);
      chk("sim_one", in_ready, 1'b1);
      chk("sim_head", rf_data, 16'h00AA);
      drain();

`ifdef ALU_WB_COND_EN
      // Z set, then NE write to r5 must be dropped
      r0 = retired;
      k0 = r5_cnt;
      step(1, 16'h0000, 3'd0, 0, 1, 4'b0100, 4'd0, 1);
      step(1, 16'h5555, 3'd5, 1, 0, 4'h0, 4'd2, 1);
      chk("chain_q", rf_valid, 1'b0);
      chk("chain_ret", retired - r0[15:0], 16'd2);
      drain();
      chk("chain_r5", r5_cnt - k0, 0);
`else
      // NV still writes back when conditions are disabled
      step(1, 16'h1234, 3'd2, 1, 0, 4'h0, 4'd15, 0);
      chk("nv_valid", rf_valid, 1'b1);
      chk("nv_data", rf_data, 16'h1234);
      drain();
`endif

      // random traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, 16'($urandom),
              3'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, 4'($urandom),
              4'($urandom), $urandom_range(0, 2) != 0);
      end

      // reset with two entries queued
      step(1, 16'hA5A5, 3'd1, 1, 1, 4'b1001, 4'd0, 0);
      step(1, 16'h5A5A, 3'd2, 1, 0, 4'h0, 4'd0, 0);
      step(0, 16'h0, 3'd0, 0, 0, 4'h0, 4'd0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", rf_valid, 1'b0);
      chk("arst_ready", in_ready, 1'b1);
      chk("arst_flags", flags_q, 4'h0);
      chk("arst_ret", retired, 16'h0);
      chk("arst_data", rf_data, 16'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 16'h0F0F, 3'd3, 1, 0, 4'h0, 4'd0, 1);
      step(0, 16'h0, 3'd0, 0, 0, 4'h0, 4'd0, 1);
      compare_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Downstream neighbour of `ALU_16`. It accepts one ALU result per handshake: data, NZCV flags, destination register and control bits from the decode stage. It keeps the architectural NZCV flag register and evaluates a 4-bit condition code against it. Results that pass the condition are buffered in a 2-entry skid queue, which drains to the register-file write port under a valid/ready handshake.

## Interface
- `DATA_W`, 16, ALU data width.
- `ADDR_W`, 3, register-file address width (8 registers).
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream result valid.
- `in_ready` output 1: block can accept this cycle.
- `alu_data` input DATA_W: `ALU_Data_Out`.
- `alu_n`, `alu_z`, `alu_c`, `alu_v` input 1 each: ALU flags.
- `dest_addr` input ADDR_W: destination register.
- `wb_en` input 1: instruction writes `alu_data` to `dest_addr`.
- `flag_en` input 1: instruction updates NZCV.
- `cond` input 4: condition code, evaluated against the current flag register.
- `rf_valid` output 1: head entry valid.
- `rf_ready` input 1: register file accepts the head entry.
- `rf_addr` output ADDR_W: head entry address.
- `rf_data` output DATA_W: head entry data.
- `flags_q` output 4: architectural `{N,Z,C,V}`.
- `retired` output 16: count of accepted instructions, wraps.

## Operation
- Accept occurs when `in_valid && in_ready`.
- On accept, `pass` = condition result computed from `flags_q` as it stands before this accept.
- Condition codes:
  - 0 AL
  - 1 EQ (Z)
  - 2 NE (!Z)
  - 3 CS (C)
  - 4 CC (!C)
  - 5 MI (N)
  - 6 PL (!N)
  - 7 VS (V)
  - 8 VC (!V)
  - 9 GE (N==V)
  - 10 LT (N!=V)
  - 11 GT (!Z && N==V)
  - 12 LE (Z || N!=V)
  - 13–15 NV (never).
- On accept with `pass && flag_en`: `flags_q` <= `{alu_n,alu_z,alu_c,alu_v}`.
- On accept with `pass && wb_en`: enqueue `{dest_addr, alu_data}`.
- On any other accept, the instruction retires with no side effect beyond `retired`.
- `retired` increments on every accept, whether or not `pass` holds, and wraps 0xFFFF→0x0000.
- Queue FSM:
  - EMPTY: enqueue → ONE.
  - ONE: enqueue only → TWO; dequeue only → EMPTY; enqueue and dequeue together → ONE, with the new entry becoming head.
  - TWO: dequeue → ONE, with the second entry promoted to head. No enqueue is possible in TWO.
- Dequeue occurs when `rf_valid && rf_ready`.
- `rf_valid` = state != EMPTY.
- `in_ready` = state != TWO. It is a decode of registered state only, with no combinational path from `rf_ready`.
- Entries drain strictly in accept order.
- `rf_addr`/`rf_data` hold stable while `rf_valid && !rf_ready`.

## Timing
- Reset values:
  - state EMPTY, so `rf_valid`=0 and `in_ready`=1.
  - `flags_q`=4'b0000.
  - `retired`=0.
  - `rf_addr`=0, `rf_data`=0.
- Reset assertion mid-operation discards queued entries immediately (asynchronous). The flag updates of instructions accepted before reset are lost.
- Accept→`rf_valid` latency: 1 cycle when the queue was EMPTY.
- Flag update visibility: an instruction accepted at edge T updates `flags_q` from T+1. The instruction accepted at edge T+1 evaluates against the updated flags.
- Sustained throughput is 1 accept per cycle while `rf_ready`=1.
- With `rf_ready`=0, at most 2 further writeback results are absorbed before `in_ready` drops.

## Configuration
- `ALU_WB_COND_EN` defined: condition evaluation as above.
- `ALU_WB_COND_EN` undefined:
  - `cond` is ignored and `pass` is constant 1.
  - The evaluator is not instantiated.
  - Flag register and queue behaviour are otherwise identical.

## Structure
- Shared package holds:
  - condition-code localparams (`COND_AL`…`COND_NV`),
  - flag bit indices (`FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0),
  - queue state encodings.
- One sub-module, `alu_cond_eval`: purely combinational, with inputs `cond` and `flags` and output `pass`.
- Top level holds the FSM, the two entry registers, `flags_q` and `retired`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with 2 entries queued → `rf_valid`=0, `in_ready`=1, `flags_q`=0, `retired`=0 without waiting for a clock edge.
- **Simple writeback:**
  - Stimulus: `alu_data`=0x0002, `dest_addr`=3, `wb_en`=1, `flag_en`=1, flags 0010, `cond`=AL.
  - Response: next cycle `rf_valid`=1, `rf_addr`=3, `rf_data`=0x0002, `flags_q`=0010.
- **Back-pressure:**
  - Stimulus: `rf_ready`=0, three back-to-back writes 0x8000, 0x4000, 0x1111.
  - Response: the third is held because `in_ready`=0 after two accepts. Raising `rf_ready` drains 0x8000 then 0x4000, then accepts 0x1111.
- **Condition chain:**
  - Stimulus: a flag-setting instruction with Z=1 (result 0x0000), then back-to-back `cond`=NE write to r5.
  - Response: the second instruction is not enqueued, r5 is never written, and `retired` increments by 2.
- **Simultaneous enqueue/dequeue:**
  - Stimulus: state ONE, accept 0x00AA while draining 0x0055.
  - Response: the state stays ONE and the next head is 0x00AA.
- **Macro off** (`ALU_WB_COND_EN` undefined): `cond`=NV with `wb_en`=1 → the entry is still enqueued.
